// File: rtl/ksa_swap_fsm.sv
// rtl/ksa_swap_fsm.sv - RC4 key-scheduling swap FSM over a single-port 256x8 S-array
module ksa_swap_fsm #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   array_init_flag,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic [7:0]             address,
  output logic [7:0]             data,
  output logic                   wren,
  input  logic [7:0]             q,
  output logic                   ksa_done_flag
);

  // kidx needs at least one bit even for a single-byte key
  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_SI  = 3'd1,
    CAP_SI = 3'd2,
    RD_SJ  = 3'd3,
    CAP_SJ = 3'd4,
    WR_SI  = 3'd5,
    WR_SJ  = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    i;
  logic [7:0]    j;
  logic [KW-1:0] kidx;
  logic [7:0]    si;
  logic [7:0]    sj;
  logic [7:0]    key_byte;

  // Select key byte kidx; byte 0 sits in the most-significant position
  always_comb begin
    key_byte = 8'd0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx == KW'(b)) begin
        key_byte = secret_key[8*(KEY_BYTES-1-b) +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: sample reads, accumulate j, advance i and the key index after each swap
  always_ff @(posedge clk) begin
    if (rst) begin
      i    <= 8'd0;
      j    <= 8'd0;
      kidx <= '0;
      si   <= 8'd0;
      sj   <= 8'd0;
    end else begin
      case (state)
        CAP_SI: begin
          si <= q;
          j  <= j + q + key_byte;
        end
        CAP_SJ: begin
          sj <= q;
        end
        WR_SJ: begin
          i    <= i + 8'd1;
          kidx <= (kidx == KW'(KEY_BYTES - 1)) ? '0 : kidx + KW'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state logic; termination is keyed on i==255 before its increment
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = array_init_flag ? RD_SI : IDLE;
      RD_SI:   state_nxt = CAP_SI;
      CAP_SI:  state_nxt = RD_SJ;
      RD_SJ:   state_nxt = CAP_SJ;
      CAP_SJ:  state_nxt = WR_SI;
      WR_SI:   state_nxt = WR_SJ;
      WR_SJ:   state_nxt = (i == 8'd255) ? DONE : RD_SI;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory interface decode: i-phase states address s[i], j-phase states address s[j]
  always_comb begin
    address       = 8'd0;
    data          = 8'd0;
    wren          = 1'b0;
    ksa_done_flag = 1'b0;
    case (state)
      RD_SI, CAP_SI: address = i;
      RD_SJ, CAP_SJ: address = j;
      WR_SI: begin
        address = i;
        data    = sj;
        wren    = 1'b1;
      end
      WR_SJ: begin
        address = j;
        data    = si;
        wren    = 1'b1;
      end
      DONE:    ksa_done_flag = 1'b1;
      default: ;
    endcase
  end

endmodule
